// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB memory slave.
//   apb_state_e   : transfer state (IDLE waits for setup, ACCESS runs the
//                   access phase including wait states)
//   APB_MAX_WAIT  : largest wait-state count the 4-bit counter can hold
//   word_index()  : byte address -> word index (drops the byte-lane bits)
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_MAX_WAIT = 15;

    // shift = log2(bytes per word); the low byte-lane bits are ignored.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input int unsigned shift);
        return addr >> shift;
    endfunction

endpackage

// File: rtl/apb_mem_slave_p_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_p_if
// APB4 completer-side bus bundle for the memory slave.
//   psel, penable, pwrite, paddr, pwdata, pstrb : driven by the requester
//   pready, pslverr, prdata                     : driven by the completer
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) and
// continues with access cycles (psel=1, penable=1). Every access-phase
// signal from the requester is held stable until the completer raises
// pready; the transfer completes on the rising edge where
// psel & penable & pready are all high. pslverr and prdata are only
// meaningful in that completion cycle (prdata only for reads).
// ---------------------------------------------------------------------------
interface apb_mem_slave_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_strb_mem.sv
// ---------------------------------------------------------------------------
// apb_strb_mem
// DEPTH x DATA_W storage with asynchronous clear, a byte-strobed write port
// and a registered read-capture port.
//   clk, rst_n : clock, asynchronous active-low clear (all words and rdata)
//   we, widx, wdata, wstrb : write enable, word index, data, byte strobes
//   cap        : load rdata this edge
//   rd_en      : when capturing, 1 loads mem[ridx], 0 loads zero
//   ridx       : word index for the capture
//   rdata      : captured read data, holds between captures
// ---------------------------------------------------------------------------
module apb_strb_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                cap,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wstrb[b]) begin
                        mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            // The caller only raises rd_en for in-range indices, so the
            // array read below never leaves the populated words.
            if (cap) begin
                rdata <= rd_en ? mem[ridx] : '0;
            end
        end
    end

endmodule

// File: rtl/apb_mem_slave_p.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_p
// Parametrised APB4 memory slave: byte-strobed writes, configurable wait
// states, out-of-range error response.
//   pclk      : bus clock, all state on the rising edge
//   presetn   : asynchronous active-low reset
//   bus       : APB completer bundle (psel/penable/pwrite/paddr/pwdata/
//               pstrb in, pready/pslverr/prdata out)
//   dbg_state : current transfer state, for observation only
// Read data is captured at the setup edge; writes commit on the
// completion edge. pready/pslverr are combinational and forced low while
// presetn is asserted.
// ---------------------------------------------------------------------------
module apb_mem_slave_p
    import apb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_mem_slave_p_if.slave    bus,
    output apb_state_e          dbg_state
);
    localparam int          BYTES    = DATA_W / 8;
    localparam int unsigned SHIFT    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

    // Parameter sanity, rejected at elaboration.
    if (DATA_W < 8 || DATA_W > 32 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("apb_mem_slave_p: DATA_W must be 8, 16, 24 or 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > APB_MAX_WAIT) begin : g_bad_wait
        $error("apb_mem_slave_p: WAIT_STATES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH * BYTES > (2 ** ADDR_W)) begin : g_bad_depth
        $error("apb_mem_slave_p: DEPTH*(DATA_W/8) exceeds the address space");
    end

    apb_state_e  state;
    logic [3:0]  cnt;

    logic [31:0] idx;
    logic        addr_err;
    logic        setup;
    logic        violation;
    logic        done;
    logic        mem_we;
    logic        rd_en;

    // Address decode. idx is only forwarded to the memory when in range,
    // so the truncation to IDX_W bits below never aliases a valid word.
    always_comb begin
        idx      = word_index(32'(bus.paddr), SHIFT);
        addr_err = (idx >= 32'(DEPTH));
    end

    // Transfer qualifiers.
    //   setup     : setup cycle seen from IDLE
    //   violation : access phase with no preceding setup -> error reply,
    //               nothing written, state unchanged
    //   done      : completion cycle of a legitimate transfer
    always_comb begin
        setup     = (state == IDLE)   &  bus.psel & ~bus.penable;
        violation = (state == IDLE)   &  bus.psel &  bus.penable;
        done      = (state == ACCESS) &  bus.psel &  bus.penable & (cnt == 4'd0);
        mem_we    = done & bus.pwrite & ~addr_err;
        rd_en     = ~bus.pwrite & ~addr_err;
    end

    // Gating with presetn drops the response immediately when reset is
    // applied mid-transfer, without waiting for the state to clear.
    assign bus.pready  = presetn & (violation | done);
    assign bus.pslverr = presetn & (violation | (done & addr_err));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state <= ACCESS;
                        cnt   <= WAIT_CNT;
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        // Requester abandoned the transfer: no write.
                        state <= IDLE;
                    end else if (bus.penable) begin
                        if (cnt == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

    apb_strb_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (pclk),
        .rst_n  (presetn),
        .we     (mem_we),
        .widx   (IDX_W'(idx)),
        .wdata  (bus.pwdata),
        .wstrb  (bus.pstrb),
        .cap    (setup),
        .rd_en  (rd_en),
        .ridx   (IDX_W'(idx)),
        .rdata  (bus.prdata)
    );

endmodule
